// File: rtl/alu_share_if.sv
// Request/response bundle between two ALU requesters, the shared-ALU arbiter and the result consumer.
interface alu_share_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_in1;
    logic [WIDTH-1:0] req0_in2;
    logic [3:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_in1;
    logic [WIDTH-1:0] req1_in2;
    logic [3:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_id;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_op,
        input  req1_valid, req1_in1, req1_in2, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_op,
        output req1_valid, req1_in1, req1_in2, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of a single ALU; the result lands in a one-deep register
// tagged with the winning port and drains through a valid/ready response channel.
module alu_share_arbiter #(
    parameter int WIDTH     = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       reset,
    alu_share_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1111;
    localparam logic       FIXED_PRIO = (PRIO_MODE != 0);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_id;
    logic             r_err;

    logic             w_can_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_sel_id;
    logic [WIDTH-1:0] w_in1;
    logic [WIDTH-1:0] w_in2;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_err;

    // MSB of the return value flags an unsupported opcode; the result field is then 0.
    function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [3:0]       op);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH:0]          res;
        sa  = a;
        sb  = b;
        res = '0;
        case (op)
            OP_ADD:  res[WIDTH-1:0] = a + b;
            OP_SUB:  res[WIDTH-1:0] = a - b;
            OP_AND:  res[WIDTH-1:0] = a & b;
            OP_OR:   res[WIDTH-1:0] = a | b;
            OP_XOR:  res[WIDTH-1:0] = a ^ b;
            OP_SLT:  res[WIDTH-1:0] = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: res[WIDTH]     = 1'b1;
        endcase
        return res;
    endfunction

    always_comb begin
        w_can_accept = ~reset & ((r_state == S_EMPTY) | bus.rsp_ready);
        w_grant0     = bus.req0_valid & (~bus.req1_valid | FIXED_PRIO | ~r_rr_ptr);
        w_grant1     = bus.req1_valid & ~w_grant0;
        w_accept     = w_can_accept & (w_grant0 | w_grant1);
        w_sel_id     = w_grant1;
        w_in1        = w_sel_id ? bus.req1_in1 : bus.req0_in1;
        w_in2        = w_sel_id ? bus.req1_in2 : bus.req0_in2;
        w_op         = w_sel_id ? bus.req1_op  : bus.req0_op;
    end

    assign {w_alu_err, w_alu_res} = alu_eval(w_in1, w_in2, w_op);

    assign bus.req0_ready = w_can_accept & w_grant0;
    assign bus.req1_ready = w_can_accept & w_grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (bus.rsp_ready & ~w_accept) w_state_nxt = S_EMPTY;
        endcase
    end

    // ALU -> result register boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= '0;
            r_zero   <= 1'b0;
            r_id     <= 1'b0;
            r_err    <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_data   <= w_alu_res;
            r_zero   <= (w_alu_res == '0);
            r_id     <= w_sel_id;
            r_err    <= w_alu_err;
            r_rr_ptr <= ~w_sel_id;
        end
    end

    assign bus.rsp_valid = (r_state == S_FULL);
    assign bus.rsp_data  = r_data;
    assign bus.rsp_zero  = r_zero;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_err   = r_err;
endmodule
